// File: rtl/pipo_bank_ctrl_pkg.sv
// Shared definitions for the PIPO bank-sequencing controller.
// Contents: legal bank-count range, per-bank state enum (derived state, for
// observation only) and the width helper for the committed-bank count.
package pipo_bank_ctrl_pkg;

    localparam int unsigned NUM_BANKS_MIN = 2;
    localparam int unsigned NUM_BANKS_MAX = 4;

    // Derived per-bank state; nothing in the controller stores it.
    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_WRITING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_state_e;

    // Width needed to count 0..num_banks committed banks.
    function automatic int unsigned used_width(input int unsigned num_banks);
        return $clog2(num_banks + 1);
    endfunction

    localparam int unsigned USED_W_MAX = $clog2(NUM_BANKS_MAX + 1);
    typedef logic [USED_W_MAX-1:0] used_t;

endpackage

// File: rtl/pipo_bank_ctrl_if.sv
// Handshake/status bundle between the PIPO controller and its environment.
// master: producer/consumer side (drives pulses and monitor qualifiers).
// slave : the controller (drives handshake, bank selects, count and flags).
interface pipo_bank_ctrl_if
    import pipo_bank_ctrl_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned BANK_W    = 1
);
    localparam int unsigned USED_W = used_width(NUM_BANKS);

    logic              i_write;
    logic              i_full_n;
    logic [BANK_W-1:0] i_bank;
    logic              t_read;
    logic              t_empty_n;
    logic [BANK_W-1:0] t_bank;
    logic              prod_done_wait;
    logic              cons_idle;
    logic [USED_W-1:0] used;
    logic              prod_stall;
    logic              cons_stall;
    logic              err_ovf;
    logic              err_udf;
    logic              clr_flags;

    modport master (
        output i_write, t_read, prod_done_wait, cons_idle, clr_flags,
        input  i_full_n, i_bank, t_empty_n, t_bank, used,
               prod_stall, cons_stall, err_ovf, err_udf
    );

    modport slave (
        input  i_write, t_read, prod_done_wait, cons_idle, clr_flags,
        output i_full_n, i_bank, t_empty_n, t_bank, used,
               prod_stall, cons_stall, err_ovf, err_udf
    );

endinterface

// File: rtl/pipo_bank_ctrl_sat_stall_counter.sv
// Saturating blocked-cycle counter with a sticky stall flag.
// Ports: ap_clk/ap_rst (sync, active-high), clr_i clears count and flag,
// cond_i = side is blocked this cycle, stall_o = sticky flag, registered.
// The flag sets on the edge after the count has reached STALL_LIMIT.
module sat_stall_counter #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned STALL_LIMIT = 1024
) (
    input  logic ap_clk,
    input  logic ap_rst,
    input  logic clr_i,
    input  logic cond_i,
    output logic stall_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall_q, stall_d;
    logic             limit_hit_c;

    // Next count/flag; clear wins over both increment and flag set.
    always_comb begin
        cnt_d       = '0;
        stall_d     = stall_q;
        limit_hit_c = (32'(cnt_q) >= STALL_LIMIT);
        if (clr_i) begin
            cnt_d   = '0;
            stall_d = 1'b0;
        end else begin
            if (cond_i) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            end
            stall_d = stall_q | limit_hit_c;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign stall_o = stall_q;

endmodule

// File: rtl/pipo_bank_ctrl.sv
// Ping-pong bank sequencer: hands whole banks from producer to consumer in
// FIFO order, generates i_full_n/t_empty_n, drives bank selects and runs
// per-side stall monitors.
// Ports: ap_clk, ap_rst (sync, active-high), bus (slave modport carrying
// pulses, handshake, bank selects, used count and sticky flags).
// All bus outputs come straight from registers.
module pipo_bank_ctrl
    import pipo_bank_ctrl_pkg::*;
#(
    parameter int unsigned NUM_BANKS   = 2,
    parameter int unsigned BANK_W      = 1,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned STALL_LIMIT = 1024
) (
    input logic           ap_clk,
    input logic           ap_rst,
    pipo_bank_ctrl_if.slave bus
);
    localparam int unsigned USED_W = used_width(NUM_BANKS);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

    logic [BANK_W-1:0] wptr_q, wptr_d;
    logic [BANK_W-1:0] rptr_q, rptr_d;
    logic [USED_W-1:0] used_q, used_d;
    logic              i_full_n_q, i_full_n_d;
    logic              t_empty_n_q, t_empty_n_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_udf_q, err_udf_d;
    logic              wr_acc_c, rd_acc_c;
    logic              prod_block_c, cons_block_c;
    logic              prod_stall_c, cons_stall_c;

    // Acceptance uses the registered handshake, so a rejected pulse is a no-op.
    always_comb begin
        wr_acc_c    = bus.i_write & i_full_n_q;
        rd_acc_c    = bus.t_read & t_empty_n_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        used_d      = used_q;
        err_ovf_d   = err_ovf_q;
        err_udf_d   = err_udf_q;

        if (wr_acc_c) begin
            wptr_d = (wptr_q == LAST_BANK) ? '0 : wptr_q + BANK_W'(1);
        end
        if (rd_acc_c) begin
            rptr_d = (rptr_q == LAST_BANK) ? '0 : rptr_q + BANK_W'(1);
        end

        case ({wr_acc_c, rd_acc_c})
            2'b10:   used_d = used_q + USED_W'(1);
            2'b01:   used_d = used_q - USED_W'(1);
            default: used_d = used_q;
        endcase

        // Handshake is registered from the next count so it tracks used exactly.
        i_full_n_d  = (used_d < USED_W'(NUM_BANKS));
        t_empty_n_d = (used_d != '0);

        if (bus.clr_flags) begin
            err_ovf_d = 1'b0;
            err_udf_d = 1'b0;
        end else begin
            err_ovf_d = err_ovf_q | (bus.i_write & ~i_full_n_q);
            err_udf_d = err_udf_q | (bus.t_read & ~t_empty_n_q);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            used_q      <= '0;
            i_full_n_q  <= 1'b1;
            t_empty_n_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_udf_q   <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            used_q      <= used_d;
            i_full_n_q  <= i_full_n_d;
            t_empty_n_q <= t_empty_n_d;
            err_ovf_q   <= err_ovf_d;
            err_udf_q   <= err_udf_d;
        end
    end

    // A side is blocked when it is waiting on the buffer and the buffer refuses it.
    assign prod_block_c = bus.prod_done_wait & ~i_full_n_q;
    assign cons_block_c = bus.cons_idle & ~t_empty_n_q;

    sat_stall_counter #(
        .CNT_W       (CNT_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_prod_mon (
        .ap_clk  (ap_clk),
        .ap_rst  (ap_rst),
        .clr_i   (bus.clr_flags),
        .cond_i  (prod_block_c),
        .stall_o (prod_stall_c)
    );

    sat_stall_counter #(
        .CNT_W       (CNT_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_cons_mon (
        .ap_clk  (ap_clk),
        .ap_rst  (ap_rst),
        .clr_i   (bus.clr_flags),
        .cond_i  (cons_block_c),
        .stall_o (cons_stall_c)
    );

    assign bus.i_full_n   = i_full_n_q;
    assign bus.i_bank     = wptr_q;
    assign bus.t_empty_n  = t_empty_n_q;
    assign bus.t_bank     = rptr_q;
    assign bus.used       = used_q;
    assign bus.err_ovf    = err_ovf_q;
    assign bus.err_udf    = err_udf_q;
    assign bus.prod_stall = prod_stall_c;
    assign bus.cons_stall = cons_stall_c;

endmodule

// File: tb/tb_pipo_bank_ctrl.sv
// Bench for pipo_bank_ctrl: a 2-bank and a 3-bank instance (STALL_LIMIT 8)
// driven by directed steps followed by random traffic, every cycle compared
// against a FIFO-count reference model of the bank hand-off rules.
module tb_pipo_bank_ctrl;

    localparam int LIMIT   = 8;
    localparam int CNT_MAX = 65535;

    logic ap_clk;
    logic rst_a  [2];
    logic i_w    [2];
    logic t_r    [2];
    logic pdw    [2];
    logic cidle  [2];
    logic clr_a  [2];

    logic [31:0] o_used  [2];
    logic [31:0] o_ibank [2];
    logic [31:0] o_tbank [2];
    logic        o_ifull [2];
    logic        o_temp  [2];
    logic        o_ps    [2];
    logic        o_cs    [2];
    logic        o_ovf   [2];
    logic        o_udf   [2];

    int tests = 0;
    int fails = 0;

    // Reference model state per instance: bank counters and committed count.
    int nb [2] = '{2, 3};
    int m_wr [2], m_rd [2], m_used [2], m_pcnt [2], m_ccnt [2];
    bit m_ovf [2], m_udf [2], m_ps [2], m_cs [2];
    int seq [7] = '{0, 1, 2, 0, 1, 2, 0};

    pipo_bank_ctrl_if #(.NUM_BANKS(2), .BANK_W(1)) if2 ();
    pipo_bank_ctrl_if #(.NUM_BANKS(3), .BANK_W(2)) if3 ();

    pipo_bank_ctrl #(.NUM_BANKS(2), .BANK_W(1), .CNT_W(16), .STALL_LIMIT(LIMIT)) dut2 (
        .ap_clk (ap_clk), .ap_rst (rst_a[0]), .bus (if2)
    );
    pipo_bank_ctrl #(.NUM_BANKS(3), .BANK_W(2), .CNT_W(16), .STALL_LIMIT(LIMIT)) dut3 (
        .ap_clk (ap_clk), .ap_rst (rst_a[1]), .bus (if3)
    );

    assign if2.i_write = i_w[0];   assign if3.i_write = i_w[1];
    assign if2.t_read = t_r[0];    assign if3.t_read = t_r[1];
    assign if2.prod_done_wait = pdw[0];  assign if3.prod_done_wait = pdw[1];
    assign if2.cons_idle = cidle[0];     assign if3.cons_idle = cidle[1];
    assign if2.clr_flags = clr_a[0];     assign if3.clr_flags = clr_a[1];

    assign o_used[0]  = 32'(if2.used);    assign o_used[1]  = 32'(if3.used);
    assign o_ibank[0] = 32'(if2.i_bank);  assign o_ibank[1] = 32'(if3.i_bank);
    assign o_tbank[0] = 32'(if2.t_bank);  assign o_tbank[1] = 32'(if3.t_bank);
    assign o_ifull[0] = if2.i_full_n;     assign o_ifull[1] = if3.i_full_n;
    assign o_temp[0]  = if2.t_empty_n;    assign o_temp[1]  = if3.t_empty_n;
    assign o_ps[0]    = if2.prod_stall;   assign o_ps[1]    = if3.prod_stall;
    assign o_cs[0]    = if2.cons_stall;   assign o_cs[1]    = if3.cons_stall;
    assign o_ovf[0]   = if2.err_ovf;      assign o_ovf[1]   = if3.err_ovf;
    assign o_udf[0]   = if2.err_udf;      assign o_udf[1]   = if3.err_udf;

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    task automatic chk(input int d, input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL d%0d %s: observed %0d expected %0d", d, tag, obs, expv);
        end
    endtask

    // Predict the effect of the upcoming clock edge from the current inputs.
    task automatic model_step(input int d);
        bit fn, en;
        if (rst_a[d] === 1'b1) begin
            m_wr[d] = 0; m_rd[d] = 0; m_used[d] = 0; m_pcnt[d] = 0; m_ccnt[d] = 0;
            m_ovf[d] = 0; m_udf[d] = 0; m_ps[d] = 0; m_cs[d] = 0;
            return;
        end
        fn = (m_used[d] < nb[d]);
        en = (m_used[d] > 0);
        if (clr_a[d]) begin
            m_ovf[d] = 0; m_udf[d] = 0; m_ps[d] = 0; m_cs[d] = 0;
            m_pcnt[d] = 0; m_ccnt[d] = 0;
        end else begin
            if (i_w[d] && !fn) m_ovf[d] = 1;
            if (t_r[d] && !en) m_udf[d] = 1;
            if (m_pcnt[d] >= LIMIT) m_ps[d] = 1;
            if (m_ccnt[d] >= LIMIT) m_cs[d] = 1;
            m_pcnt[d] = (pdw[d] && !fn) ? ((m_pcnt[d] == CNT_MAX) ? CNT_MAX : m_pcnt[d] + 1) : 0;
            m_ccnt[d] = (cidle[d] && !en) ? ((m_ccnt[d] == CNT_MAX) ? CNT_MAX : m_ccnt[d] + 1) : 0;
        end
        if (i_w[d] && fn) begin
            m_wr[d] = (m_wr[d] + 1) % nb[d];
            m_used[d]++;
        end
        if (t_r[d] && en) begin
            m_rd[d] = (m_rd[d] + 1) % nb[d];
            m_used[d]--;
        end
    endtask

    task automatic check_dut(input int d);
        chk(d, "used",       o_used[d],  32'(m_used[d]));
        chk(d, "i_full_n",   32'(o_ifull[d]), 32'(m_used[d] < nb[d]));
        chk(d, "t_empty_n",  32'(o_temp[d]),  32'(m_used[d] > 0));
        chk(d, "i_bank",     o_ibank[d], 32'(m_wr[d]));
        chk(d, "t_bank",     o_tbank[d], 32'(m_rd[d]));
        chk(d, "err_ovf",    32'(o_ovf[d]), 32'(m_ovf[d]));
        chk(d, "err_udf",    32'(o_udf[d]), 32'(m_udf[d]));
        chk(d, "prod_stall", 32'(o_ps[d]),  32'(m_ps[d]));
        chk(d, "cons_stall", 32'(o_cs[d]),  32'(m_cs[d]));
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(negedge ap_clk);
        check_dut(0);
        check_dut(1);
    endtask

    task automatic chk_reset_vals(input int d, input string tag);
        chk(d, {tag, " used"},      o_used[d], 0);
        chk(d, {tag, " i_full_n"},  32'(o_ifull[d]), 1);
        chk(d, {tag, " t_empty_n"}, 32'(o_temp[d]), 0);
        chk(d, {tag, " i_bank"},    o_ibank[d], 0);
        chk(d, {tag, " t_bank"},    o_tbank[d], 0);
        chk(d, {tag, " flags"},
            32'({o_ovf[d], o_udf[d], o_ps[d], o_cs[d]}), 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_a[d] = 1'b1; i_w[d] = 1'b0; t_r[d] = 1'b0;
            pdw[d] = 1'b0; cidle[d] = 1'b0; clr_a[d] = 1'b0;
        end
        tick();
        tick();
        rst_a[0] = 1'b0;
        rst_a[1] = 1'b0;
        tick();
        chk_reset_vals(0, "reset");
        chk_reset_vals(1, "reset");

        // Two commits into the 2-bank buffer fill it.
        i_w[0] = 1'b1; tick(); i_w[0] = 1'b0; tick();
        i_w[0] = 1'b1; tick(); i_w[0] = 1'b0;
        chk(0, "fill used", o_used[0], 2);
        chk(0, "fill i_full_n", 32'(o_ifull[0]), 0);
        chk(0, "fill i_bank", o_ibank[0], 0);
        chk(0, "fill t_bank", o_tbank[0], 0);
        chk(0, "fill t_empty_n", 32'(o_temp[0]), 1);

        // Full: write rejected, read accepted.
        i_w[0] = 1'b1; t_r[0] = 1'b1; tick(); i_w[0] = 1'b0; t_r[0] = 1'b0;
        chk(0, "full rw err_ovf", 32'(o_ovf[0]), 1);
        chk(0, "full rw used", o_used[0], 1);
        chk(0, "full rw t_bank", o_tbank[0], 1);
        chk(0, "full rw i_full_n", 32'(o_ifull[0]), 1);

        // used = 1: both accepted, both pointers wrap/advance.
        i_w[0] = 1'b1; t_r[0] = 1'b1; tick(); i_w[0] = 1'b0; t_r[0] = 1'b0;
        chk(0, "both used", o_used[0], 1);
        chk(0, "both i_bank", o_ibank[0], 1);
        chk(0, "both t_bank", o_tbank[0], 0);

        // Drain, then underflow and clear.
        t_r[0] = 1'b1; tick(); tick(); t_r[0] = 1'b0;
        chk(0, "udf flag", 32'(o_udf[0]), 1);
        chk(0, "udf i_bank", o_ibank[0], 1);
        chk(0, "udf t_bank", o_tbank[0], 1);
        clr_a[0] = 1'b1; tick(); clr_a[0] = 1'b0;
        chk(0, "clr err_udf", 32'(o_udf[0]), 0);
        chk(0, "clr err_ovf", 32'(o_ovf[0]), 0);

        // Consumer stall: 8 blocked cycles, flag one edge later.
        cidle[0] = 1'b1;
        repeat (8) tick();
        chk(0, "cstall at 8", 32'(o_cs[0]), 0);
        tick();
        chk(0, "cstall at 9", 32'(o_cs[0]), 1);
        cidle[0] = 1'b0; clr_a[0] = 1'b1; tick(); clr_a[0] = 1'b0;
        chk(0, "cstall cleared", 32'(o_cs[0]), 0);
        cidle[0] = 1'b1; repeat (4) tick();
        cidle[0] = 1'b0; tick();
        cidle[0] = 1'b1; repeat (8) tick();
        chk(0, "cstall broken run", 32'(o_cs[0]), 0);
        cidle[0] = 1'b0;

        // Producer stall against a full buffer.
        i_w[0] = 1'b1; tick(); tick(); i_w[0] = 1'b0;
        pdw[0] = 1'b1; repeat (9) tick(); pdw[0] = 1'b0;
        chk(0, "pstall set", 32'(o_ps[0]), 1);
        clr_a[0] = 1'b1; tick(); clr_a[0] = 1'b0;
        t_r[0] = 1'b1; tick(); tick(); t_r[0] = 1'b0;

        // 3 banks: interleaved writes/reads walk 0,1,2,0,...
        for (int k = 0; k < 7; k++) begin
            chk(1, "seq i_bank", o_ibank[1], 32'(seq[k]));
            i_w[1] = 1'b1; tick(); i_w[1] = 1'b0;
            chk(1, "seq t_bank", o_tbank[1], 32'(seq[k]));
            t_r[1] = 1'b1; tick(); t_r[1] = 1'b0;
        end
        t_r[1] = 1'b1; tick(); t_r[1] = 1'b0;
        i_w[1] = 1'b1; tick(); tick();
        chk(1, "pre-reset used", o_used[1], 2);
        rst_a[1] = 1'b1; t_r[1] = 1'b1; tick();
        rst_a[1] = 1'b0; i_w[1] = 1'b0; t_r[1] = 1'b0;
        chk_reset_vals(1, "midrst");
        tick();

        // Random traffic, write-biased then read-biased to visit full and empty.
        for (int n = 0; n < 600; n++) begin
            for (int d = 0; d < 2; d++) begin
                i_w[d]   = (n < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                t_r[d]   = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                pdw[d]   = ($urandom_range(0, 7) != 0);
                cidle[d] = ($urandom_range(0, 7) != 0);
                clr_a[d] = ($urandom_range(0, 40) == 0);
                rst_a[d] = ($urandom_range(0, 150) == 0);
            end
            tick();
        end

        for (int d = 0; d < 2; d++) begin
            i_w[d] = 1'b0; t_r[d] = 1'b0; pdw[d] = 1'b0;
            cidle[d] = 1'b0; clr_a[d] = 1'b0; rst_a[d] = 1'b0;
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
